// File: rtl/lcd_timing_pattern_gen_if.sv
// LCD output bus of the timing/pattern generator plus its run-time controls.
// The generator side (master) drives the panel signals and overlay markers;
// the consumer side (slave) supplies the pattern select and solid colour.
interface lcd_timing_pattern_gen_if;
  logic [1:0]  Mode;
  logic [15:0] SolidRGB;
  logic        LCD_DE;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [15:0] PixX;
  logic [15:0] PixY;
  logic        FrameStart;
  logic [15:0] FrameCnt;

  modport master (
    input  Mode, SolidRGB,
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
    output PixX, PixY, FrameStart, FrameCnt
  );

  modport slave (
    output Mode, SolidRGB,
    input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
    input  PixX, PixY, FrameStart, FrameCnt
  );
endinterface

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB565 parallel-LCD timing generator with test-pattern engine.
// Stage 1 holds the raster position (h,v), frame counter, latched mode and the
// colour-bar state; stage 2 registers every pin and overlay output from it.
module lcd_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 210,
  parameter int unsigned H_SYNC     = 1,
  parameter int unsigned H_BP       = 182,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 45,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 0,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CHK_LOG2   = 5,
  parameter int unsigned GRAD_SHIFT = 4
) (
  input  logic                      PixelClk,
  input  logic                      RST,
  lcd_timing_pattern_gen_if.master  lcd
);

  // Region boundaries along each axis: sync, back porch, active, front porch.
  localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
  localparam logic [15:0] H_ACT_BEG  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END  = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] H_LAST     = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
  localparam logic [15:0] V_ACT_BEG  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END  = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] V_LAST     = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

  // Bars are H_ACTIVE/8 wide; the guard keeps tiny panels from a zero width.
  localparam int unsigned BAR_W    = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  // Counter stage
  logic [15:0] h_r;
  logic [15:0] v_r;
  logic [15:0] frame_cnt_r;
  logic [1:0]  mode_r;
  logic [15:0] bar_cnt_r;
  logic [2:0]  bar_idx_r;

  logic        h_last_s;
  logic        v_last_s;
  logic [15:0] h_nxt_s;
  logic [15:0] v_nxt_s;
  logic [15:0] bar_cnt_nxt_s;
  logic [2:0]  bar_idx_nxt_s;

  // Decode of the current position
  logic        h_act_s;
  logic        v_act_s;
  logic        de_s;
  logic        hsync_s;
  logic        vsync_s;
  logic        frame_start_s;
  logic [15:0] pix_x_s;
  logic [15:0] pix_y_s;
  logic        chk_s;
  logic [5:0]  grey_s;
  logic [15:0] rgb_s;

  // Output stage
  logic        de_r;
  logic        hsync_r;
  logic        vsync_r;
  logic [15:0] rgb_r;
  logic [15:0] pix_x_r;
  logic [15:0] pix_y_r;
  logic        frame_start_r;
  logic [15:0] frame_cnt_out_r;

  assign h_last_s      = (h_r == H_LAST);
  assign v_last_s      = (v_r == V_LAST);
  assign h_act_s       = (h_r >= H_ACT_BEG) && (h_r < H_ACT_END);
  assign v_act_s       = (v_r >= V_ACT_BEG) && (v_r < V_ACT_END);
  assign de_s          = h_act_s && v_act_s;
  assign hsync_s       = (h_r < H_SYNC_END) ? HS_POL : ~HS_POL;
  assign vsync_s       = (v_r < V_SYNC_END) ? VS_POL : ~VS_POL;
  assign frame_start_s = (h_r == 16'h0000) && (v_r == 16'h0000);
  assign pix_x_s       = de_s ? (h_r - H_ACT_BEG) : 16'h0000;
  assign pix_y_s       = de_s ? (v_r - V_ACT_BEG) : 16'h0000;
  assign chk_s         = pix_x_s[CHK_LOG2] ^ pix_y_s[CHK_LOG2];

  // Raster advance: line wrap steps v, and a frame wrap lands on (0,0) in one step.
  always_comb begin
    h_nxt_s = h_r;
    v_nxt_s = v_r;
    if (h_last_s) begin
      h_nxt_s = 16'h0000;
      v_nxt_s = v_last_s ? 16'h0000 : (v_r + 16'h0001);
    end else begin
      h_nxt_s = h_r + 16'h0001;
      v_nxt_s = v_r;
    end
  end

  // Bar state tracks the pixel at h_r; cleared just before each line's active start.
  always_comb begin
    bar_cnt_nxt_s = bar_cnt_r;
    bar_idx_nxt_s = bar_idx_r;
    if (h_nxt_s == H_ACT_BEG) begin
      bar_cnt_nxt_s = 16'h0000;
      bar_idx_nxt_s = 3'd0;
    end else if (h_act_s) begin
      if (bar_cnt_r == BAR_LAST) begin
        bar_cnt_nxt_s = 16'h0000;
        bar_idx_nxt_s = (bar_idx_r == 3'd7) ? 3'd7 : (bar_idx_r + 3'd1);
      end else begin
        bar_cnt_nxt_s = bar_cnt_r + 16'h0001;
        bar_idx_nxt_s = bar_idx_r;
      end
    end else begin
      bar_cnt_nxt_s = bar_cnt_r;
      bar_idx_nxt_s = bar_idx_r;
    end
  end

  // Counter stage register: mode and frame count change on the frame-wrap edge only.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      h_r         <= 16'h0000;
      v_r         <= 16'h0000;
      frame_cnt_r <= 16'h0000;
      mode_r      <= 2'd0;
      bar_cnt_r   <= 16'h0000;
      bar_idx_r   <= 3'd0;
    end else begin
      h_r       <= h_nxt_s;
      v_r       <= v_nxt_s;
      bar_cnt_r <= bar_cnt_nxt_s;
      bar_idx_r <= bar_idx_nxt_s;
      if (h_last_s && v_last_s) begin
        frame_cnt_r <= frame_cnt_r + 16'h0001;
        mode_r      <= lcd.Mode;
      end
    end
  end

  // Pattern colour for the current position; blank outside the active area.
  always_comb begin
    rgb_s  = 16'h0000;
    grey_s = 6'(pix_x_s >> GRAD_SHIFT);
    if (de_s) begin
      case (mode_r)
        2'd0: rgb_s = {(bar_idx_r[1] ? 5'h00 : 5'h1F),
                       (bar_idx_r[2] ? 6'h00 : 6'h3F),
                       (bar_idx_r[0] ? 5'h00 : 5'h1F)};
        2'd1: rgb_s = {grey_s[5:1], grey_s, grey_s[5:1]};
        2'd2: rgb_s = chk_s ? 16'hFFFF : 16'h0000;
        2'd3: rgb_s = lcd.SolidRGB;
        default: rgb_s = 16'h0000;
      endcase
    end else begin
      rgb_s = 16'h0000;
    end
  end

  // Output register: every pin lags the counter stage by exactly one clock.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      de_r            <= 1'b0;
      hsync_r         <= ~HS_POL;
      vsync_r         <= ~VS_POL;
      rgb_r           <= 16'h0000;
      pix_x_r         <= 16'h0000;
      pix_y_r         <= 16'h0000;
      frame_start_r   <= 1'b0;
      frame_cnt_out_r <= 16'h0000;
    end else begin
      de_r            <= de_s;
      hsync_r         <= hsync_s;
      vsync_r         <= vsync_s;
      rgb_r           <= rgb_s;
      pix_x_r         <= pix_x_s;
      pix_y_r         <= pix_y_s;
      frame_start_r   <= frame_start_s;
      frame_cnt_out_r <= frame_cnt_r;
    end
  end

  assign lcd.LCD_DE     = de_r;
  assign lcd.LCD_HSYNC  = hsync_r;
  assign lcd.LCD_VSYNC  = vsync_r;
  assign lcd.LCD_R      = rgb_r[15:11];
  assign lcd.LCD_G      = rgb_r[10:5];
  assign lcd.LCD_B      = rgb_r[4:0];
  assign lcd.PixX       = pix_x_r;
  assign lcd.PixY       = pix_y_r;
  assign lcd.FrameStart = frame_start_r;
  assign lcd.FrameCnt   = frame_cnt_out_r;

endmodule
